// File: rtl/mux_seq_pkg.sv
// Shared types and sizes for the round-robin mux select sequencer.
package mux_seq_pkg;

    localparam int CHAN_W   = 2;
    localparam int NUM_CHAN = 4;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETTLE = 2'd1,
        S_HOLD   = 2'd2
    } state_t;

endpackage

// File: rtl/mux_seq_next_chan.sv
// Rotating-priority channel finder: first enabled channel after cur_i, wrapping back
// to cur_i itself last.
module mux_seq_next_chan
    import mux_seq_pkg::*;
(
    input  logic [CHAN_W-1:0]   cur_i,
    input  logic [NUM_CHAN-1:0] mask_i,
    output logic [CHAN_W-1:0]   next_o,
    output logic                valid_o,
    output logic                wrapped_o
);

    logic [CHAN_W-1:0] cand;

    // Walk offsets from farthest to nearest so the nearest enabled channel wins.
    always_comb begin
        next_o  = cur_i;
        valid_o = 1'b0;
        cand    = cur_i;
        for (int i = NUM_CHAN; i >= 1; i--) begin
            cand = cur_i + CHAN_W'(i);
            if (mask_i[cand]) begin
                next_o  = cand;
                valid_o = 1'b1;
            end
        end
        wrapped_o = valid_o && (next_o <= cur_i);
    end

endmodule

// File: rtl/mux_select_sequencer.sv
// Scans the 4:1 mux inputs round-robin, pulsing sample after a settle time and holding
// each channel for a programmable dwell.
//
//   state    | meaning
//   S_IDLE   | not scanning, selects hold last channel
//   S_SETTLE | new select applied, counting down to the sample pulse
//   S_HOLD   | dwell after sample, period ends when counter reaches zero
module mux_select_sequencer
    import mux_seq_pkg::*;
#(
    parameter int DWELL_W = 8,
    parameter int SETTLE  = 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic                stop,
    input  logic [NUM_CHAN-1:0] enable_mask,
    input  logic [DWELL_W-1:0]  dwell,
    output logic                select_0,
    output logic                select_1,
    output logic [CHAN_W-1:0]   chan,
    output logic                sample,
    output logic                round,
    output logic                busy
);

    localparam int SET_W = (SETTLE > 0) ? $clog2(SETTLE + 1) : 1;
    localparam int CNT_W = ((DWELL_W > SET_W) ? DWELL_W : SET_W) + 1;
    localparam logic [CNT_W-1:0] SETTLE_LD = CNT_W'(SETTLE);

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [CHAN_W-1:0] chan_q, chan_d;
    logic              stop_pend_q, stop_pend_d;

    logic [CHAN_W-1:0] cur_sel;
    logic [CHAN_W-1:0] nxt_chan;
    logic              nxt_valid;
    logic              nxt_wrapped;
    logic              period_end;

    // From IDLE, searching after channel 3 yields the lowest enabled channel.
    assign cur_sel = (state_q == S_IDLE) ? CHAN_W'(NUM_CHAN - 1) : chan_q;

    mux_seq_next_chan u_next_chan (
        .cur_i     (cur_sel),
        .mask_i    (enable_mask),
        .next_o    (nxt_chan),
        .valid_o   (nxt_valid),
        .wrapped_o (nxt_wrapped)
    );

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        chan_d      = chan_q;
        stop_pend_d = stop_pend_q;
        sample      = 1'b0;
        round       = 1'b0;
        period_end  = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start && nxt_valid) begin
                    chan_d  = nxt_chan;
                    cnt_d   = SETTLE_LD;
                    state_d = S_SETTLE;
                end
            end
            S_SETTLE: begin
                if (stop) stop_pend_d = 1'b1;
                if (cnt_q == '0) begin
                    sample = 1'b1;
                    if (dwell == '0) begin
                        period_end = 1'b1;
                    end else begin
                        cnt_d   = CNT_W'(dwell) - CNT_W'(1);
                        state_d = S_HOLD;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            S_HOLD: begin
                if (stop) stop_pend_d = 1'b1;
                if (cnt_q == '0) period_end = 1'b1;
                else             cnt_d = cnt_q - CNT_W'(1);
            end
            default: state_d = S_IDLE;
        endcase

        if (period_end) begin
            if (stop_pend_q || stop || !nxt_valid) begin
                state_d     = S_IDLE;
                stop_pend_d = 1'b0;
                round       = 1'b1;
            end else begin
                chan_d  = nxt_chan;
                cnt_d   = SETTLE_LD;
                state_d = S_SETTLE;
                round   = nxt_wrapped;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            chan_q      <= '0;
            stop_pend_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            chan_q      <= chan_d;
            stop_pend_q <= stop_pend_d;
        end
    end

    assign chan     = chan_q;
    assign select_0 = chan_q[1];
    assign select_1 = chan_q[0];
    assign busy     = (state_q != S_IDLE);

endmodule

// File: tb/tb_mux_select_sequencer.sv
// Directed bench: dut_a runs with SETTLE=1, dut_b with SETTLE=0.
module tb_mux_select_sequencer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset;
    logic       a_start, a_stop, b_start, b_stop;
    logic [3:0] a_mask, b_mask;
    logic [7:0] a_dwell, b_dwell;
    logic       a_sel0, a_sel1, a_sample, a_round, a_busy;
    logic       b_sel0, b_sel1, b_sample, b_round, b_busy;
    logic [1:0] a_chan, b_chan;

    int n_chk = 0;
    int n_err = 0;

    mux_select_sequencer #(.DWELL_W(8), .SETTLE(1)) dut_a (
        .clk(clk), .reset(reset), .start(a_start), .stop(a_stop),
        .enable_mask(a_mask), .dwell(a_dwell),
        .select_0(a_sel0), .select_1(a_sel1), .chan(a_chan),
        .sample(a_sample), .round(a_round), .busy(a_busy)
    );

    mux_select_sequencer #(.DWELL_W(8), .SETTLE(0)) dut_b (
        .clk(clk), .reset(reset), .start(b_start), .stop(b_stop),
        .enable_mask(b_mask), .dwell(b_dwell),
        .select_0(b_sel0), .select_1(b_sel1), .chan(b_chan),
        .sample(b_sample), .round(b_round), .busy(b_busy)
    );

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic chk_a(input string t, input int c, input int ch, input int smp,
                         input int rnd, input int bsy);
        chk($sformatf("%s c%0d chan", t, c), int'(a_chan), ch);
        chk($sformatf("%s c%0d sel", t, c), int'({a_sel0, a_sel1}), ch);
        chk($sformatf("%s c%0d sample", t, c), int'(a_sample), smp);
        chk($sformatf("%s c%0d round", t, c), int'(a_round), rnd);
        chk($sformatf("%s c%0d busy", t, c), int'(a_busy), bsy);
    endtask

    task automatic chk_b(input string t, input int c, input int ch, input int smp,
                         input int rnd, input int bsy);
        chk($sformatf("%s c%0d chan", t, c), int'(b_chan), ch);
        chk($sformatf("%s c%0d sel", t, c), int'({b_sel0, b_sel1}), ch);
        chk($sformatf("%s c%0d sample", t, c), int'(b_sample), smp);
        chk($sformatf("%s c%0d round", t, c), int'(b_round), rnd);
        chk($sformatf("%s c%0d busy", t, c), int'(b_busy), bsy);
    endtask

    task automatic next_cyc;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        reset   = 1'b1;
        a_start = 1'b0; a_stop = 1'b0; a_mask = 4'b0000; a_dwell = 8'd0;
        b_start = 1'b0; b_stop = 1'b0; b_mask = 4'b0000; b_dwell = 8'd0;
        next_cyc;
        next_cyc;
        reset = 1'b0;
    endtask

    task automatic start_a;
        a_start = 1'b1;
        next_cyc;
        a_start = 1'b0;
    endtask

    initial begin
        int ch;
        do_reset;
        @(negedge clk);
        chk_a("reset", 0, 0, 0, 0, 0);
        chk_b("reset", 0, 0, 0, 0, 0);

        // 1: full mask, 4-cycle periods, sample at k=1, round closing channel 3
        next_cyc;
        a_mask = 4'b1111; a_dwell = 8'd2;
        start_a;
        for (int c = 0; c < 16; c++) begin
            @(negedge clk);
            ch = (c / 4) % 4;
            chk_a("t1", c, ch, int'(c % 4 == 1), int'(c % 4 == 3 && ch == 3), 1);
            next_cyc;
        end

        // 2: sparse mask, dwell 0 -> channels 1,3 with 2-cycle periods
        do_reset;
        a_mask = 4'b1010; a_dwell = 8'd0;
        start_a;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            ch = ((c / 2) % 2 == 1) ? 3 : 1;
            chk_a("t2", c, ch, int'(c % 2 == 1), int'(c % 2 == 1 && ch == 3), 1);
            next_cyc;
        end

        // 3: start with empty mask is ignored
        do_reset;
        a_mask = 4'b0000; a_dwell = 8'd2;
        start_a;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk_a("t3", c, 0, 0, 0, 0);
            next_cyc;
        end

        // 4: stop at k=0 of channel 2 finishes that period then idles on channel 2
        do_reset;
        a_mask = 4'b1111; a_dwell = 8'd2;
        start_a;
        for (int c = 0; c < 16; c++) begin
            a_stop = (c == 8);
            @(negedge clk);
            if (c < 12) begin
                ch = c / 4;
                chk_a("t4", c, ch, int'(c % 4 == 1), int'(c == 11), 1);
            end else begin
                chk_a("t4", c, 2, 0, 0, 0);
            end
            next_cyc;
        end
        a_stop = 1'b0;

        // 5: reset during HOLD of channel 3
        do_reset;
        a_mask = 4'b1111; a_dwell = 8'd2;
        start_a;
        for (int c = 0; c < 14; c++) next_cyc;
        @(negedge clk);
        chk_a("t5 pre", 14, 3, 0, 0, 1);
        reset = 1'b1;
        next_cyc;
        reset = 1'b0;
        @(negedge clk);
        chk_a("t5 post", 15, 0, 0, 0, 0);
        next_cyc;
        @(negedge clk);
        chk_a("t5 post", 16, 0, 0, 0, 0);

        // 6: SETTLE=0, dwell 0 -> advance and sample every cycle; mask narrows then clears
        do_reset;
        b_mask = 4'b1111; b_dwell = 8'd0;
        b_start = 1'b1;
        next_cyc;
        b_start = 1'b0;
        for (int c = 0; c < 15; c++) begin
            b_mask = (c >= 13) ? 4'b0000 : (c >= 8) ? 4'b0100 : 4'b1111;
            @(negedge clk);
            if (c < 8)       chk_b("t6", c, c % 4, 1, int'(c % 4 == 3), 1);
            else if (c == 8) chk_b("t6", c, 0, 1, 0, 1);
            else if (c < 14) chk_b("t6", c, 2, 1, 1, 1);
            else             chk_b("t6", c, 2, 0, 0, 0);
            next_cyc;
        end

        // 7: start and stop together in IDLE -> start wins, scan keeps running
        do_reset;
        a_mask = 4'b1111; a_dwell = 8'd2;
        a_start = 1'b1; a_stop = 1'b1;
        next_cyc;
        a_start = 1'b0; a_stop = 1'b0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            chk_a("t7", c, c / 4, int'(c % 4 == 1), 0, 1);
            next_cyc;
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
